heap_surge_controller: RTL

//  Front-end controller for pipelined_heap_wrapper in the surge protector.

---
 rtl/heap_surge_controller_if.sv | 50 +++++
 rtl/heap_surge_controller.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/heap_surge_controller_if.sv
// Signal bundle between heap_surge_controller and its surroundings: requesters,
// the heap wrapper's enque/deque-secondary ports, the eviction port and status.
interface heap_surge_controller_if #(
    parameter int unsigned NUM_REQ                = 4,
    parameter int unsigned HEAP_MAX_NUM_ENTRIES   = 1024,
    parameter int unsigned HEAP_ENTRY_VALUE_WIDTH = 32,
    parameter int unsigned HEAP_PRIORITY_AWIDTH   = 8
);
    localparam int unsigned VW = HEAP_ENTRY_VALUE_WIDTH;
    localparam int unsigned PW = HEAP_PRIORITY_AWIDTH;
    localparam int unsigned SW = $clog2(HEAP_MAX_NUM_ENTRIES) + 1;

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*VW-1:0] req_value;
    logic [NUM_REQ*PW-1:0] req_priority;
    logic                  heap_enque_en;
    logic                  heap_enque_ready;
    logic [VW-1:0]         heap_enque_value;
    logic [PW-1:0]         heap_enque_priority;
    logic                  heap_sec_req_en;
    logic                  heap_sec_req_ready;
    logic                  heap_sec_en;
    logic                  heap_sec_ready;
    logic [VW-1:0]         heap_sec_value;
    logic [PW-1:0]         heap_sec_priority;
    logic [SW-1:0]         heap_size;
    logic                  evict_valid;
    logic                  evict_ready;
    logic [VW-1:0]         evict_value;
    logic [PW-1:0]         evict_priority;
    logic                  surge_active;
    logic [31:0]           evict_count;

    modport master (
        input  req_valid, req_value, req_priority, heap_enque_ready, heap_sec_req_ready,
               heap_sec_ready, heap_sec_value, heap_sec_priority, heap_size, evict_ready,
        output req_ready, heap_enque_en, heap_enque_value, heap_enque_priority,
               heap_sec_req_en, heap_sec_en, evict_valid, evict_value, evict_priority,
               surge_active, evict_count
    );

    modport slave (
        output req_valid, req_value, req_priority, heap_enque_ready, heap_sec_req_ready,
               heap_sec_ready, heap_sec_value, heap_sec_priority, heap_size, evict_ready,
        input  req_ready, heap_enque_en, heap_enque_value, heap_enque_priority,
               heap_sec_req_en, heap_sec_en, evict_valid, evict_value, evict_priority,
               surge_active, evict_count
    );
endinterface

// File: rtl/heap_surge_controller.sv
// Round-robin enque arbiter plus surge-driven eviction sequencer in front of the
// pipelined heap wrapper; evicted entries leave on a registered valid/ready port.
module heap_surge_controller #(
    parameter int unsigned NUM_REQ                = 4,
    parameter int unsigned HEAP_MAX_NUM_ENTRIES   = 1024,
    parameter int unsigned HEAP_ENTRY_VALUE_WIDTH = 32,
    parameter int unsigned HEAP_PRIORITY_AWIDTH   = 8,
    parameter int unsigned HIGH_WATERMARK         = 960,
    parameter int unsigned LOW_WATERMARK          = 896
) (
    input logic                      clk,
    input logic                      rst_n,
    heap_surge_controller_if.master  bus
);
    localparam int unsigned VW       = HEAP_ENTRY_VALUE_WIDTH;
    localparam int unsigned PW       = HEAP_PRIORITY_AWIDTH;
    localparam int unsigned SW       = $clog2(HEAP_MAX_NUM_ENTRIES) + 1;
    localparam int unsigned PTR_W    = $clog2(NUM_REQ);
    localparam int unsigned LAST_REQ = NUM_REQ - 1;

    localparam logic [PTR_W:0]   NUM_REQ_L  = NUM_REQ[PTR_W:0];
    localparam logic [PTR_W-1:0] LAST_REQ_L = LAST_REQ[PTR_W-1:0];
    localparam logic [SW-1:0]    HIGH_L     = HIGH_WATERMARK[SW-1:0];
    localparam logic [SW-1:0]    LOW_L      = LOW_WATERMARK[SW-1:0];

    if (!(NUM_REQ >= 2 && LOW_WATERMARK < HIGH_WATERMARK &&
          HIGH_WATERMARK <= HEAP_MAX_NUM_ENTRIES)) begin : g_param_check
        $error("heap_surge_controller: illegal NUM_REQ or watermark parameters");
    end

    typedef enum logic [1:0] {StIdle, StReq, StResp, StOut} state_e;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d, grant;
    logic [PTR_W:0]   cand;
    logic             found, enq_hs;
    logic             surge_q, surge_d;
    logic             evict_valid_q, evict_valid_d;
    logic [VW-1:0]    evict_value_q, evict_value_d;
    logic [PW-1:0]    evict_prio_q, evict_prio_d;
    logic [31:0]      evict_count_q, evict_count_d;
    logic             sec_req_en, sec_en;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant = rr_ptr_q;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + k[PTR_W:0];
            if (cand >= NUM_REQ_L) cand = cand - NUM_REQ_L;
            if (!found && bus.req_valid[cand[PTR_W-1:0]]) begin
                grant = cand[PTR_W-1:0];
                found = 1'b1;
            end
        end
    end

    assign enq_hs = found & bus.heap_enque_ready;

    always_comb begin
        bus.req_ready = '0;
        if (enq_hs) bus.req_ready[grant] = 1'b1;
        rr_ptr_d = rr_ptr_q;
        if (enq_hs) rr_ptr_d = (grant == LAST_REQ_L) ? '0 : grant + 1'b1;
    end

    assign bus.heap_enque_en       = enq_hs;
    assign bus.heap_enque_value    = bus.req_value[grant*VW +: VW];
    assign bus.heap_enque_priority = bus.req_priority[grant*PW +: PW];

    // Hysteresis: between the watermarks the flag holds its previous value.
    always_comb begin
        surge_d = surge_q;
        if (bus.heap_size >= HIGH_L) surge_d = 1'b1;
        else if (bus.heap_size <= LOW_L) surge_d = 1'b0;
    end

    always_comb begin
        state_d       = state_q;
        sec_req_en    = 1'b0;
        sec_en        = 1'b0;
        evict_valid_d = evict_valid_q;
        evict_value_d = evict_value_q;
        evict_prio_d  = evict_prio_q;
        evict_count_d = evict_count_q;
        unique case (state_q)
            StIdle: if (surge_q) state_d = StReq;
            StReq: begin
                if (!surge_q) begin
                    state_d = StIdle;
                end else begin
                    sec_req_en = 1'b1;
                    if (bus.heap_sec_req_ready) state_d = StResp;
                end
            end
            // Request already accepted by the wrapper, so the response must be drained.
            StResp: begin
                sec_en = bus.heap_sec_ready;
                if (bus.heap_sec_ready) begin
                    evict_value_d = bus.heap_sec_value;
                    evict_prio_d  = bus.heap_sec_priority;
                    evict_valid_d = 1'b1;
                    state_d       = StOut;
                end
            end
            StOut: begin
                if (bus.evict_ready) begin
                    evict_valid_d = 1'b0;
                    if (evict_count_q != 32'hFFFF_FFFF) evict_count_d = evict_count_q + 32'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            rr_ptr_q      <= '0;
            surge_q       <= 1'b0;
            evict_valid_q <= 1'b0;
            evict_value_q <= '0;
            evict_prio_q  <= '0;
            evict_count_q <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            surge_q       <= surge_d;
            evict_valid_q <= evict_valid_d;
            evict_value_q <= evict_value_d;
            evict_prio_q  <= evict_prio_d;
            evict_count_q <= evict_count_d;
        end
    end

    assign bus.heap_sec_req_en = sec_req_en;
    assign bus.heap_sec_en     = sec_en;
    assign bus.evict_valid     = evict_valid_q;
    assign bus.evict_value     = evict_value_q;
    assign bus.evict_priority  = evict_prio_q;
    assign bus.surge_active    = surge_q;
    assign bus.evict_count     = evict_count_q;
endmodule
